// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single 16-bit physical memory.
// Define MEM_ARBITER_ROUND_ROBIN_EN to add a round-robin tie-break pointer; otherwise data always wins ties.
module mem_arbiter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_read,
    input  logic [15:0] i_address,
    output logic [15:0] i_rdata,
    output logic        i_resp,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [15:0] d_address,
    input  logic [15:0] d_wdata,
    input  logic [1:0]  d_byte_enable,
    output logic [15:0] d_rdata,
    output logic        d_resp,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [15:0] pmem_address,
    output logic [15:0] pmem_wdata,
    output logic [1:0]  pmem_byte_enable,
    input  logic [15:0] pmem_rdata,
    input  logic        pmem_resp
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RESP} state_t;

    state_t      state;
    state_t      state_next;
    logic        grant_d;
    logic        grant_i;
    logic        data_first;
    logic        serve_done;

    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [1:0]  be_q;
    logic        rd_q;
    logic        wr_q;
    logic        i_resp_q;
    logic        d_resp_q;
    logic [15:0] i_rdata_q;
    logic [15:0] d_rdata_q;

    assign serve_done = ((state == SERVE_I) || (state == SERVE_D)) && pmem_resp;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    // ptr = 1 means the instruction port wins the next tie.
    logic ptr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= 1'b0;
        end else if (serve_done) begin
            ptr <= (state == SERVE_D);
        end
    end

    assign data_first = ~ptr;
`else
    assign data_first = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_d    = 1'b0;
        grant_i    = 1'b0;
        case (state)
            IDLE: begin
                if ((d_read || d_write) && (data_first || !i_read)) begin
                    grant_d    = 1'b1;
                    state_next = SERVE_D;
                end else if (i_read) begin
                    grant_i    = 1'b1;
                    state_next = SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The latched request doubles as the registered memory command; rd/wr drop as soon as memory answers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q    <= 16'h0000;
            wdata_q   <= 16'h0000;
            be_q      <= 2'b00;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            i_resp_q  <= 1'b0;
            d_resp_q  <= 1'b0;
            i_rdata_q <= 16'h0000;
            d_rdata_q <= 16'h0000;
        end else begin
            if (grant_d) begin
                addr_q  <= d_address;
                wdata_q <= d_wdata;
                be_q    <= d_byte_enable;
                wr_q    <= d_write;
                rd_q    <= ~d_write;
            end else if (grant_i) begin
                addr_q  <= i_address;
                wdata_q <= 16'h0000;
                be_q    <= 2'b11;
                wr_q    <= 1'b0;
                rd_q    <= 1'b1;
            end

            if (serve_done) begin
                rd_q      <= 1'b0;
                wr_q      <= 1'b0;
                i_resp_q  <= (state == SERVE_I);
                d_resp_q  <= (state == SERVE_D);
                i_rdata_q <= (state == SERVE_I) ? pmem_rdata : 16'h0000;
                d_rdata_q <= ((state == SERVE_D) && !wr_q) ? pmem_rdata : 16'h0000;
            end else if (state == RESP) begin
                i_resp_q  <= 1'b0;
                d_resp_q  <= 1'b0;
                i_rdata_q <= 16'h0000;
                d_rdata_q <= 16'h0000;
            end
        end
    end

    assign pmem_read        = rd_q;
    assign pmem_write       = wr_q;
    assign pmem_address     = addr_q;
    assign pmem_wdata       = wdata_q;
    assign pmem_byte_enable = be_q;
    assign i_resp           = i_resp_q;
    assign d_resp           = d_resp_q;
    assign i_rdata          = i_rdata_q;
    assign d_rdata          = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random request mixes,
// all checked against a transaction-level model of pending requests and grant order.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_read;
    logic [15:0] i_address;
    logic [15:0] i_rdata;
    logic        i_resp;
    logic        d_read;
    logic        d_write;
    logic [15:0] d_address;
    logic [15:0] d_wdata;
    logic [1:0]  d_byte_enable;
    logic [15:0] d_rdata;
    logic        d_resp;
    logic        pmem_read;
    logic        pmem_write;
    logic [15:0] pmem_address;
    logic [15:0] pmem_wdata;
    logic [1:0]  pmem_byte_enable;
    logic [15:0] pmem_rdata;
    logic        pmem_resp;

    int total = 0;
    int bad   = 0;

    // Model: what each port still has outstanding, plus who was served last for tie-breaking.
    bit          m_i_pend;
    logic [15:0] m_i_addr;
    bit          m_d_pend;
    bit          m_d_is_write;
    logic [15:0] m_d_addr;
    logic [15:0] m_d_wdata;
    logic [1:0]  m_d_be;
    bit          m_last_was_data;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .i_read           (i_read),
        .i_address        (i_address),
        .i_rdata          (i_rdata),
        .i_resp           (i_resp),
        .d_read           (d_read),
        .d_write          (d_write),
        .d_address        (d_address),
        .d_wdata          (d_wdata),
        .d_byte_enable    (d_byte_enable),
        .d_rdata          (d_rdata),
        .d_resp           (d_resp),
        .pmem_read        (pmem_read),
        .pmem_write       (pmem_write),
        .pmem_address     (pmem_address),
        .pmem_wdata       (pmem_wdata),
        .pmem_byte_enable (pmem_byte_enable),
        .pmem_rdata       (pmem_rdata),
        .pmem_resp        (pmem_resp)
    );

    task automatic check_output(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, " pmem_cmd"}, 16'({pmem_read, pmem_write}), 16'h0000);
        check_output({tag, " pmem_address"}, pmem_address, 16'h0000);
        check_output({tag, " pmem_wdata"}, pmem_wdata, 16'h0000);
        check_output({tag, " pmem_be"}, 16'(pmem_byte_enable), 16'h0000);
        check_output({tag, " resps"}, 16'({i_resp, d_resp}), 16'h0000);
        check_output({tag, " i_rdata"}, i_rdata, 16'h0000);
        check_output({tag, " d_rdata"}, d_rdata, 16'h0000);
    endtask

    // Called at an IDLE negedge; raises the requested ports and records them in the model.
    task automatic apply_stimulus(input bit ir, input logic [15:0] ia, input bit dr, input bit dw,
                                  input logic [15:0] da, input logic [15:0] dwd, input logic [1:0] dbe);
        i_read        = ir;
        i_address     = ia;
        d_read        = dr;
        d_write       = dw;
        d_address     = da;
        d_wdata       = dwd;
        d_byte_enable = dbe;
        m_i_pend      = ir;
        m_i_addr      = ia;
        m_d_pend      = dr || dw;
        m_d_is_write  = dw;
        m_d_addr      = da;
        m_d_wdata     = dwd;
        m_d_be        = dbe;
    endtask

    function automatic bit model_pick_data();
        bit tie_to_data;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        tie_to_data = !m_last_was_data;
`else
        tie_to_data = 1'b1;
`endif
        return m_d_pend && (!m_i_pend || tie_to_data);
    endfunction

    // One full transaction: memory answers on SERVE cycle n; ends at the following IDLE negedge.
    task automatic serve_one(input bit is_data, input int n, input logic [15:0] mem_data);
        bit          exp_wr;
        logic [15:0] exp_addr;
        logic [1:0]  exp_be;
        exp_wr   = is_data && m_d_is_write;
        exp_addr = is_data ? m_d_addr : m_i_addr;
        exp_be   = is_data ? m_d_be : 2'b11;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            check_output("serve pmem_read", 16'(pmem_read), 16'(!exp_wr));
            check_output("serve pmem_write", 16'(pmem_write), 16'(exp_wr));
            check_output("serve pmem_address", pmem_address, exp_addr);
            check_output("serve pmem_be", 16'(pmem_byte_enable), 16'(exp_be));
            if (is_data) check_output("serve pmem_wdata", pmem_wdata, m_d_wdata);
            check_output("serve no resp", 16'({i_resp, d_resp}), 16'h0000);
            if (k == n) begin
                pmem_resp  = 1'b1;
                pmem_rdata = mem_data;
            end
        end
        @(negedge clk);
        pmem_resp  = 1'b0;
        pmem_rdata = 16'($urandom);
        check_output("resp i_resp", 16'(i_resp), 16'(!is_data));
        check_output("resp d_resp", 16'(d_resp), 16'(is_data));
        check_output("resp i_rdata", i_rdata, is_data ? 16'h0000 : mem_data);
        check_output("resp d_rdata", d_rdata, (is_data && !m_d_is_write) ? mem_data : 16'h0000);
        check_output("resp pmem_cmd", 16'({pmem_read, pmem_write}), 16'h0000);
        if (is_data) begin
            d_read   = 1'b0;
            d_write  = 1'b0;
            m_d_pend = 1'b0;
        end else begin
            i_read   = 1'b0;
            m_i_pend = 1'b0;
        end
        m_last_was_data = is_data;
        @(negedge clk);
        check_output("idle resps", 16'({i_resp, d_resp}), 16'h0000);
        check_output("idle pmem_cmd", 16'({pmem_read, pmem_write}), 16'h0000);
    endtask

    task automatic run_pending(input int n);
        while (m_i_pend || m_d_pend) begin
            serve_one(model_pick_data(), n, 16'($urandom));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n         = 1'b0;
        pmem_resp       = 1'b0;
        pmem_rdata      = 16'h0000;
        m_last_was_data = 1'b0;
        apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
        #12;
        check_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_all_zero("after reset");

        $display("[TB] instruction read, zero-wait memory");
        apply_stimulus(1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
        serve_one(1'b0, 1, 16'h1234);

        $display("[TB] data write, four serve cycles");
        apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0101, 16'hABCD, 2'b10);
        serve_one(1'b1, 4, 16'h5555);

        $display("[TB] simultaneous instruction and data reads");
        apply_stimulus(1'b1, 16'h0200, 1'b1, 1'b0, 16'h0300, 16'h0000, 2'b11);
        run_pending(1);

        $display("[TB] read and write together act as write");
        apply_stimulus(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0777, 16'h1357, 2'b01);
        run_pending(2);

        $display("[TB] reset during data serve");
        apply_stimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0A0A, 16'h0000, 2'b11);
        @(negedge clk);
        check_output("pre-reset pmem_read", 16'(pmem_read), 16'h0001);
        #2 reset_n = 1'b0;
        #1 check_all_zero("mid reset");
        apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
        m_last_was_data = 1'b0;
        @(negedge clk);
        reset_n    = 1'b1;
        pmem_resp  = 1'b1;
        pmem_rdata = 16'hBEEF;
        repeat (3) begin
            @(negedge clk);
            check_all_zero("stray pmem_resp");
        end
        pmem_resp = 1'b0;
        apply_stimulus(1'b1, 16'h0F00, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
        serve_one(1'b0, 1, 16'h4321);

        $display("[TB] random request mixes");
        for (int it = 0; it < 40; it++) begin
            bit      ir;
            int      dk;
            ir = 1'($urandom_range(0, 1));
            dk = int'($urandom_range(0, 3));
            if (!ir && dk == 0) ir = 1'b1;
            apply_stimulus(ir, 16'($urandom), dk[0], dk[1], 16'($urandom), 16'($urandom), 2'($urandom));
            run_pending(int'($urandom_range(1, 4)));
            if ($urandom_range(0, 3) == 0) begin
                pmem_resp = 1'b1;
                @(negedge clk);
                check_output("idle stray resp", 16'({i_resp, d_resp}), 16'h0000);
                check_output("idle stray cmd", 16'({pmem_read, pmem_write}), 16'h0000);
                pmem_resp = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
